prbs_err_counter: RTL and testbench

PRBS_ERR_COUNTER -- requirements
Module: prbs_err_counter

---
 rtl/prbs_err_pkg.sv | 19 +
 rtl/bit_counter.sv | 22 ++
 rtl/prbs_err_counter.sv | 167 ++++++++++++++++
 tb/tb_prbs_err_counter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_err_pkg.sv
// rtl/prbs_err_pkg.sv - shared constants and sizing helpers for the PRBS error blocks
//   CHUNK_W       : popcount chunk width
//   ACC_W_DEFAULT : default accumulator width
//   nchunk(w)     : number of CHUNK_W chunks covering w bits (top chunk zero-padded)
//   cnt_w(w)      : bits needed to hold a count of 0..w
package prbs_err_pkg;

    localparam int CHUNK_W       = 16;
    localparam int ACC_W_DEFAULT = 48;

    function automatic int nchunk(input int width);
        return (width + CHUNK_W - 1) / CHUNK_W;
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - combinational popcount of one WIDTH-bit vector
//   data  : input vector
//   count : number of ones in data
module bit_counter
    import prbs_err_pkg::*;
#(
    parameter int WIDTH = CHUNK_W
) (
    input  logic [WIDTH-1:0]        data,
    output logic [cnt_w(WIDTH)-1:0] count
);

    localparam int CW = cnt_w(WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/prbs_err_counter.sv
// rtl/prbs_err_counter.sv - pipelined bit-error counter with totals, windows and saturation
//   CLK_I, RST_I          : clock, synchronous active-high reset
//   DATA_I, VALID_I       : error vector (1 = bit error) and its qualifier
//   CLR_I                 : synchronous clear of counters and pipeline
//   WIN_LEN_I             : window length in accumulated words, 0 = continuous
//   WORD_ERR_O/_VLD_O     : popcount of one accepted word, two cycles after acceptance
//   ERR_CNT_O, BIT_CNT_O  : saturating totals of errors and compared bits
//   WIN_ERR_O, WIN_DONE_O : error count of last completed window, window-end pulse
//   SAT_O                 : sticky, set when any accumulator saturates
//   THRESH_I, ALARM_O     : window-sum threshold alarm, present only with PRBS_ERR_THRESH_EN
module prbs_err_counter
    import prbs_err_pkg::*;
#(
    parameter int WIDTH = 80,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [WIDTH-1:0]        DATA_I,
    input  logic                    VALID_I,
    input  logic                    CLR_I,
    input  logic [31:0]             WIN_LEN_I,
`ifdef PRBS_ERR_THRESH_EN
    input  logic [ACC_W-1:0]        THRESH_I,
    output logic                    ALARM_O,
`endif
    output logic [cnt_w(WIDTH)-1:0] WORD_ERR_O,
    output logic                    WORD_ERR_VLD_O,
    output logic [ACC_W-1:0]        ERR_CNT_O,
    output logic [ACC_W-1:0]        BIT_CNT_O,
    output logic [ACC_W-1:0]        WIN_ERR_O,
    output logic                    WIN_DONE_O,
    output logic                    SAT_O
);

    localparam int NCHUNK = nchunk(WIDTH);
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int CNT_W  = cnt_w(WIDTH);
    localparam int CCNT_W = cnt_w(CHUNK_W);
    localparam int SUM_W  = cnt_w(PAD_W);

    logic [PAD_W-1:0]  padded;
    logic [CCNT_W-1:0] chunk_cnt [NCHUNK];
    logic [CCNT_W-1:0] chunk_q   [NCHUNK];
    logic              s1_vld;
    logic [SUM_W-1:0]  chunk_sum;

    logic [ACC_W-1:0]  win_acc;
    logic [31:0]       word_cnt;

    logic [ACC_W:0]    err_sum;
    logic [ACC_W:0]    bit_sum;
    logic [ACC_W:0]    win_sum;
    logic [ACC_W-1:0]  err_next;
    logic [ACC_W-1:0]  bit_next;
    logic [ACC_W-1:0]  win_next;
    logic [32:0]       cnt_inc;
    logic              win_en;
    logic              win_close;
    logic              sat_hit;

    // Upper chunk bits beyond WIDTH stay zero so they never count as errors.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = DATA_I;
    end

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        bit_counter #(
            .WIDTH (CHUNK_W)
        ) u_bit_counter (
            .data  (padded[g*CHUNK_W +: CHUNK_W]),
            .count (chunk_cnt[g])
        );
    end

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            chunk_sum = chunk_sum + SUM_W'(chunk_q[i]);
        end
    end

    // One extra carry bit per adder detects overflow; the result clamps to all-ones.
    always_comb begin
        err_sum   = {1'b0, ERR_CNT_O} + (ACC_W+1)'(WORD_ERR_O);
        bit_sum   = {1'b0, BIT_CNT_O} + (ACC_W+1)'(WIDTH);
        win_sum   = {1'b0, win_acc}   + (ACC_W+1)'(WORD_ERR_O);
        err_next  = err_sum[ACC_W] ? '1 : err_sum[ACC_W-1:0];
        bit_next  = bit_sum[ACC_W] ? '1 : bit_sum[ACC_W-1:0];
        win_next  = win_sum[ACC_W] ? '1 : win_sum[ACC_W-1:0];
        win_en    = (WIN_LEN_I != 32'd0);
        cnt_inc   = {1'b0, word_cnt} + 33'd1;
        // >= rather than == so a window shortened below the running count closes on the next word.
        win_close = (cnt_inc >= {1'b0, WIN_LEN_I});
        sat_hit   = err_sum[ACC_W] | bit_sum[ACC_W] | (win_en & win_sum[ACC_W]);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            s1_vld         <= 1'b0;
            for (int i = 0; i < NCHUNK; i++) begin
                chunk_q[i] <= '0;
            end
            WORD_ERR_O     <= '0;
            WORD_ERR_VLD_O <= 1'b0;
            ERR_CNT_O      <= '0;
            BIT_CNT_O      <= '0;
            WIN_ERR_O      <= '0;
            WIN_DONE_O     <= 1'b0;
            SAT_O          <= 1'b0;
            win_acc        <= '0;
            word_cnt       <= '0;
        end else begin
            // CLR_I kills both pipeline stages, including the word presented with it.
            s1_vld <= VALID_I & ~CLR_I;
            if (VALID_I && !CLR_I) begin
                for (int i = 0; i < NCHUNK; i++) begin
                    chunk_q[i] <= chunk_cnt[i];
                end
            end
            WORD_ERR_VLD_O <= s1_vld & ~CLR_I;
            if (s1_vld && !CLR_I) begin
                WORD_ERR_O <= CNT_W'(chunk_sum);
            end

            WIN_DONE_O <= 1'b0;
            if (CLR_I) begin
                ERR_CNT_O <= '0;
                BIT_CNT_O <= '0;
                WIN_ERR_O <= '0;
                SAT_O     <= 1'b0;
                win_acc   <= '0;
                word_cnt  <= '0;
            end else if (WORD_ERR_VLD_O) begin
                ERR_CNT_O <= err_next;
                BIT_CNT_O <= bit_next;
                if (sat_hit) begin
                    SAT_O <= 1'b1;
                end
                if (win_en) begin
                    if (win_close) begin
                        WIN_ERR_O  <= win_next;
                        WIN_DONE_O <= 1'b1;
                        win_acc    <= '0;
                        word_cnt   <= '0;
                    end else begin
                        win_acc    <= win_next;
                        word_cnt   <= cnt_inc[31:0];
                    end
                end
            end
        end
    end

`ifdef PRBS_ERR_THRESH_EN
    // word_cnt == 0 marks the first word of a window, which drops the previous window's alarm.
    always_ff @(posedge CLK_I) begin
        if (RST_I || CLR_I) begin
            ALARM_O <= 1'b0;
        end else if (WORD_ERR_VLD_O && win_en) begin
            ALARM_O <= ((word_cnt != 32'd0) & ALARM_O) | (win_next > THRESH_I);
        end
    end
`endif

endmodule

// File: tb/tb_prbs_err_counter.sv
// tb/tb_prbs_err_counter.sv - self-checking bench for prbs_err_counter
module tb_prbs_err_counter;

    localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic [79:0] data = '0;
    logic [31:0] win_len = '0;

    logic [7:0]  word_err;
    logic        word_vld;
    logic [47:0] err_cnt, bit_cnt, win_err;
    logic        win_done, sat;

    logic [7:0]  word_err16;
    logic        word_vld16;
    logic [15:0] err16, bits16, win_err16;
    logic        win_done16, sat16;

`ifdef PRBS_ERR_THRESH_EN
    logic [47:0] thresh = '1;
    logic        alarm, alarm16;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prbs_err_counter #(.WIDTH(80), .ACC_W(48)) dut (
        .CLK_I          (clk),
        .RST_I          (rst),
        .DATA_I         (data),
        .VALID_I        (valid),
        .CLR_I          (clr),
        .WIN_LEN_I      (win_len),
`ifdef PRBS_ERR_THRESH_EN
        .THRESH_I       (thresh),
        .ALARM_O        (alarm),
`endif
        .WORD_ERR_O     (word_err),
        .WORD_ERR_VLD_O (word_vld),
        .ERR_CNT_O      (err_cnt),
        .BIT_CNT_O      (bit_cnt),
        .WIN_ERR_O      (win_err),
        .WIN_DONE_O     (win_done),
        .SAT_O          (sat)
    );

    prbs_err_counter #(.WIDTH(80), .ACC_W(16)) dut16 (
        .CLK_I          (clk),
        .RST_I          (rst),
        .DATA_I         (data),
        .VALID_I        (valid),
        .CLR_I          (clr),
        .WIN_LEN_I      (win_len),
`ifdef PRBS_ERR_THRESH_EN
        .THRESH_I       (thresh[15:0]),
        .ALARM_O        (alarm16),
`endif
        .WORD_ERR_O     (word_err16),
        .WORD_ERR_VLD_O (word_vld16),
        .ERR_CNT_O      (err16),
        .BIT_CNT_O      (bits16),
        .WIN_ERR_O      (win_err16),
        .WIN_DONE_O     (win_done16),
        .SAT_O          (sat16)
    );

    // Reference model: queue of accepted words with their age in edges.
    typedef struct { int pc; int age; } ent_t;
    ent_t   q[$];
    longint m_err = 0, m_bits = 0, m_wsum = 0, m_win_err = 0;
    longint m_wcnt = 0;
    bit     m_sat = 0, m_done = 0, m_vld = 0;
    int     m_word = 0;

    typedef struct { logic [79:0] data; int exp_pc; } vec_t;
    vec_t vec[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_acc(input int pc, input longint wl);
        if (m_err + pc > MAX48) begin m_err = MAX48; m_sat = 1; end else m_err += pc;
        if (m_bits + 80 > MAX48) begin m_bits = MAX48; m_sat = 1; end else m_bits += 80;
        if (wl != 0) begin
            m_wcnt++;
            if (m_wsum + pc > MAX48) begin m_wsum = MAX48; m_sat = 1; end else m_wsum += pc;
            if (m_wcnt >= wl) begin
                m_win_err = m_wsum;
                m_done    = 1;
                m_wcnt    = 0;
                m_wsum    = 0;
            end
        end
    endtask

    task automatic model_edge(input bit v, input int pc, input bit c, input bit r, input longint wl);
        ent_t e;
        if (r || c) begin
            q.delete();
            m_err = 0; m_bits = 0; m_wsum = 0; m_wcnt = 0; m_win_err = 0;
            m_sat = 0; m_done = 0; m_vld = 0;
            if (r) m_word = 0;
        end else begin
            m_done = 0;
            m_vld  = 0;
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].age == 1) begin m_word = q[i].pc; m_vld = 1; end
            end
            if (q.size() > 0 && q[0].age == 2) begin
                model_acc(q[0].pc, wl);
                void'(q.pop_front());
            end
            if (v) begin
                e.pc = pc; e.age = 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [79:0] d, input bit c, input bit r);
        valid = v; data = d; clr = c; rst = r;
        @(posedge clk);
        #1;
        model_edge(v, $countones(d), c, r, longint'(win_len));
        chk("model_word_vld", word_vld, m_vld);
        if (m_vld) chk("model_word_err", word_err, m_word);
        chk("model_err_cnt", err_cnt, m_err);
        chk("model_bit_cnt", bit_cnt, m_bits);
        chk("model_win_err", win_err, m_win_err);
        chk("model_win_done", win_done, m_done);
        chk("model_sat", sat, m_sat);
    endtask

    function automatic logic [79:0] rnd_word();
        logic [79:0] one = 80'h1;
        logic [79:0] d;
        case ($urandom_range(0, 5))
            0: d = '0;
            1: d = '1;
            2: d = one << $urandom_range(0, 79);
            default: d = {$urandom(), $urandom(), 16'($urandom())};
        endcase
        return d;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [79:0] ones = '1;

        vec[0] = '{80'h8AAF, 9};
        vec[1] = '{80'h0AAF, 8};
        vec[2] = '{80'hCAAF, 10};
        vec[3] = '{80'h0, 0};
        vec[4] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80};
        vec[5] = '{80'h1, 1};
        vec[6] = '{80'h8000_0000_0000_0000_0000, 1};
        vec[7] = '{80'hFFFF_0000_0000_0000_0000, 16};

        // Reset state
        cycle(0, '0, 0, 1);
        chk("rst_word_err", word_err, 0);
        chk("rst_word_vld", word_vld, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_win_done", win_done, 0);
        chk("rst_sat", sat, 0);

        // Single-word table: popcount at n+2, totals at n+3
        for (int i = 0; i < 8; i++) begin
            cycle(0, '0, 1, 0);
            cycle(1, vec[i].data, 0, 0);
            cycle(0, '0, 0, 0);
            chk("tbl_word_vld", word_vld, 1);
            chk("tbl_word_err", word_err, vec[i].exp_pc);
            chk("tbl_err_early", err_cnt, 0);
            cycle(0, '0, 0, 0);
            chk("tbl_err_cnt", err_cnt, vec[i].exp_pc);
            chk("tbl_bit_cnt", bit_cnt, 80);
        end

        // Back-to-back words
        cycle(0, '0, 1, 0);
        cycle(1, 80'h0AAF, 0, 0);
        cycle(1, 80'h8AAF, 0, 0);
        chk("b2b_w0", word_err, 8);
        cycle(1, 80'hCAAF, 0, 0);
        chk("b2b_w1", word_err, 9);
        cycle(0, '0, 0, 0);
        chk("b2b_w2", word_err, 10);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 0);
        chk("b2b_err_cnt", err_cnt, 27);
        chk("b2b_bit_cnt", bit_cnt, 240);

        // Windows of four words
        win_len = 4;
        cycle(0, '0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(i < 4, (i < 4) ? ones : 80'h0, 0, 0);
            if (win_done) pulses++;
        end
        chk("win_pulses", pulses, 1);
        chk("win_err_320", win_err, 320);
        pulses = 0;
        cycle(1, ones, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 0, 0);
            if (win_done) pulses++;
        end
        chk("win_fifth_no_pulse", pulses, 0);
        win_len = 0;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(i < 5, (i < 5) ? ones : 80'h0, 0, 0);
            if (win_done) pulses++;
        end
        chk("win_off_no_pulse", pulses, 0);
        chk("win_off_hold", win_err, 320);

        // Saturation on the 16-bit build
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 819; i++) cycle(1, ones, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
        chk("sat16_below_err", err16, 65520);
        chk("sat16_below_flag", sat16, 0);
        cycle(1, ones, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
        chk("sat16_err", err16, 65535);
        chk("sat16_bits", bits16, 65535);
        chk("sat16_flag", sat16, 1);
        for (int i = 0; i < 5; i++) cycle(1, ones, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
        chk("sat16_stuck_err", err16, 65535);
        chk("sat16_sticky", sat16, 1);
        cycle(0, '0, 1, 0);
        chk("sat16_clr_err", err16, 0);
        chk("sat16_clr_flag", sat16, 0);

        // CLR one cycle after a word drops it
        cycle(1, 80'h8AAF, 0, 0);
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 0, 0);
            chk("clr_drop_err", err_cnt, 0);
        end

        // RST mid-stream
        for (int i = 0; i < 3; i++) cycle(1, ones, 0, 0);
        cycle(1, ones, 0, 1);
        chk("midrst_word_err", word_err, 0);
        chk("midrst_word_vld", word_vld, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_bit_cnt", bit_cnt, 0);
        chk("midrst_win_err", win_err, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 0, 0);
            chk("midrst_after_err", err_cnt, 0);
        end
        cycle(1, 80'h8AAF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
        chk("midrst_restart_err", err_cnt, 9);

`ifdef PRBS_ERR_THRESH_EN
        // Threshold alarm
        win_len = 2;
        thresh  = 48'd10;
        cycle(0, '0, 1, 0);
        cycle(1, 80'hCAAF, 0, 0);
        cycle(1, 80'h1, 0, 0);
        cycle(0, '0, 0, 0);
        chk("alarm_first_word", alarm, 0);
        cycle(0, '0, 0, 0);
        chk("alarm_set", alarm, 1);
        chk("alarm_win_done", win_done, 1);
        chk("alarm_win_err", win_err, 11);
        cycle(1, 80'h0, 0, 0);
        cycle(0, '0, 0, 0);
        chk("alarm_hold", alarm, 1);
        cycle(0, '0, 0, 0);
        chk("alarm_cleared", alarm, 0);
        thresh  = '1;
        win_len = 0;
`endif

        // Randomized traffic against the model
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) win_len = $urandom_range(0, 5);
            cycle($urandom_range(0, 3) != 0, rnd_word(),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
